tsu_axis_rx: RTL

Receive-side PTP timestamp unit. Passively taps the 8-bit RX MAC AXI-Stream in the `rtc_clk` domain and latches the RTC time at the first beat of every frame. It parses L2 PTP frames (Ethertype 0x88F7, optionally behind one 802.1Q tag) and queues {timestamp, messageType, sequenceId} for event messages in a small FIFO read by the PTP servo. It is the receive counterpart of `tsu_axis_tx` and consumes the same `sync_time_ptp_ns` from `rtc_mini`.

---
 rtl/tsu_pkg.sv | 45 ++++
 rtl/tsu_axis_rx_if.sv | 26 ++
 rtl/tsu_ts_fifo.sv | 56 +++++
 rtl/tsu_axis_rx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/tsu_pkg.sv
// Shared constants and helpers for the PTP timestamp units (RX and TX).
// Provides Ethertypes, PTP event message types, the timestamp record layout
// and PTP header field offsets.
package tsu_pkg;

  localparam logic [15:0] ETHERTYPE_PTP  = 16'h88F7;
  localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;

  // PTP event message types; anything above PDELAY_RESP is a general message.
  localparam logic [3:0] SYNC        = 4'd0;
  localparam logic [3:0] DELAY_REQ   = 4'd1;
  localparam logic [3:0] PDELAY_REQ  = 4'd2;
  localparam logic [3:0] PDELAY_RESP = 4'd3;

  // Record: {timestamp[63:0], msg_type[3:0], seq_id[15:0]}, MSB first.
  localparam int unsigned REC_W       = 84;
  localparam int unsigned REC_SEQ_LSB = 0;
  localparam int unsigned REC_MSG_LSB = 16;
  localparam int unsigned REC_TS_LSB  = 20;

  // Ethernet framing, byte offsets from the first byte of the frame.
  localparam int unsigned ETH_TYPE_OFF = 12;
  localparam int unsigned ETH_HDR_LEN  = 14;
  localparam int unsigned VLAN_TAG_LEN = 4;

  // PTP common header field offsets, relative to the header base.
  localparam int unsigned PTP_MSGTYPE_OFF = 0;
  localparam int unsigned PTP_SEQID_OFF   = 30;

  typedef logic [REC_W-1:0] ts_rec_t;

  function automatic ts_rec_t pack_rec(logic [63:0] ts, logic [3:0] msg, logic [15:0] seq);
    ts_rec_t r;
    r = '0;
    r[REC_TS_LSB +: 64]  = ts;
    r[REC_MSG_LSB +: 4]  = msg;
    r[REC_SEQ_LSB +: 16] = seq;
    return r;
  endfunction

  function automatic logic is_event_msg(logic [3:0] msg);
    return (msg == SYNC) || (msg == DELAY_REQ) || (msg == PDELAY_REQ) || (msg == PDELAY_RESP);
  endfunction

endpackage

// File: rtl/tsu_axis_rx_if.sv
// Bus bundle for tsu_axis_rx: the passive RX byte-stream tap (no tready) and
// the timestamp record stream read by the PTP servo, plus the drop counter.
//   slave  : the timestamp unit (consumes s_axis_*, produces ts_*)
//   master : the environment (MAC tap driver and servo)
interface tsu_axis_rx_if;
  import tsu_pkg::*;

  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  ts_rec_t     ts_tdata;
  logic        ts_tvalid;
  logic        ts_tready;
  logic [15:0] ts_drop_cnt;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, ts_tready,
    output ts_tdata, ts_tvalid, ts_drop_cnt
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, ts_tready,
    input  ts_tdata, ts_tvalid, ts_drop_cnt
  );

endinterface

// File: rtl/tsu_ts_fifo.sv
// Synchronous first-word-fall-through FIFO for timestamp records.
// Ports:
//   clk, reset    : clock, synchronous active-high reset (flushes the FIFO)
//   push, push_data : write request and data
//   pop           : read request; ignored while empty
//   head          : head entry, forced to zero while empty
//   full, empty   : occupancy flags
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; a pop on an empty FIFO is ignored even if a push arrives with it.
module tsu_ts_fifo #(
  parameter int unsigned WIDTH   = 84,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 32'(1) << FIFO_AW;
  localparam logic [FIFO_AW:0] PtrOne = {{FIFO_AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic             pop_ok, push_ok;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]) &&
                   (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // When full with a simultaneous pop, the write lands in the slot being
  // vacated; the head is read before the edge, so ordering is preserved.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q[FIFO_AW-1:0]];

endmodule

// File: rtl/tsu_axis_rx.sv
// Receive-side PTP timestamp unit.
// Passively taps the 8-bit RX MAC stream, latches RTC time (minus ingress
// latency) at the first beat of every frame, parses L2 PTP (optionally behind
// one 802.1Q tag) and queues {timestamp, msg_type, seq_id} for event messages.
// Ports:
//   rtc_clk      : sole clock
//   reset        : synchronous, active-high
//   rtc_timer_in : RTC time in ns
//   bus          : s_axis_* tap in, ts_* record stream out, ts_drop_cnt
module tsu_axis_rx import tsu_pkg::*; #(
  parameter int unsigned FIFO_AW       = 3,
  parameter logic [63:0] RX_LATENCY_NS = 64'd0
) (
  input  logic          rtc_clk,
  input  logic          reset,
  input  logic [63:0]   rtc_timer_in,
  tsu_axis_rx_if.slave  bus
);

  localparam logic [2:0] StResync = 3'd0;
  localparam logic [2:0] StIdle   = 3'd1;
  localparam logic [2:0] StHdr    = 3'd2;
  localparam logic [2:0] StPtp    = 3'd3;
  localparam logic [2:0] StTail   = 3'd4;
  localparam logic [2:0] StDrop   = 3'd5;

  localparam logic [10:0] IdxMax        = 11'h7FF;
  localparam logic [10:0] EtypeIdxUntag = 11'(ETH_TYPE_OFF);
  localparam logic [10:0] EtypeIdxTag   = 11'(ETH_TYPE_OFF + VLAN_TAG_LEN);
  localparam logic [10:0] PtpBaseUntag  = 11'(ETH_HDR_LEN);
  localparam logic [10:0] PtpBaseTag    = 11'(ETH_HDR_LEN + VLAN_TAG_LEN);

  logic [2:0]  state_q, state_d;
  logic [10:0] idx_q, idx_d;
  logic        vlan_q, vlan_d;
  logic [7:0]  etype_hi_q, etype_hi_d;
  logic [7:0]  seq_hi_q, seq_hi_d;
  logic [3:0]  msg_type_q, msg_type_d;
  logic [15:0] seq_id_q, seq_id_d;
  logic [63:0] ts_cap_q, ts_cap_d;
  logic [15:0] drop_cnt_q;

  logic        beat, last_beat;
  logic [10:0] etype_idx, ptp_base;
  logic [15:0] etype;
  logic        push;
  logic        fifo_full, fifo_empty, fifo_drop;
  ts_rec_t     fifo_head;

  assign beat      = bus.s_axis_tvalid;
  assign last_beat = bus.s_axis_tvalid && bus.s_axis_tlast;
  assign etype_idx = vlan_q ? EtypeIdxTag : EtypeIdxUntag;
  assign ptp_base  = vlan_q ? PtpBaseTag : PtpBaseUntag;
  assign etype     = {etype_hi_q, bus.s_axis_tdata};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    vlan_d     = vlan_q;
    etype_hi_d = etype_hi_q;
    seq_hi_d   = seq_hi_q;
    msg_type_d = msg_type_q;
    seq_id_d   = seq_id_q;
    ts_cap_d   = ts_cap_q;
    push       = 1'b0;

    if (beat && (idx_q != IdxMax)) idx_d = idx_q + 11'd1;

    unique case (state_q)
      // Wait for a gap (or a frame end) so a frame cut by reset is never parsed.
      StResync: begin
        if (!beat || last_beat) state_d = StIdle;
      end
      StIdle: begin
        if (beat) begin
          ts_cap_d = rtc_timer_in - RX_LATENCY_NS;
          idx_d    = 11'd1;
          vlan_d   = 1'b0;
          if (!last_beat) state_d = StHdr;
        end
      end
      StHdr: begin
        if (beat) begin
          if (idx_q == etype_idx) begin
            etype_hi_d = bus.s_axis_tdata;
          end else if (idx_q == etype_idx + 11'd1) begin
            // Only one tag is accepted; a second 0x8100 falls to DROP.
            if ((etype == ETHERTYPE_VLAN) && !vlan_q) vlan_d = 1'b1;
            else if (etype == ETHERTYPE_PTP)         state_d = StPtp;
            else                                     state_d = StDrop;
          end
          if (last_beat) state_d = StIdle;
        end
      end
      StPtp: begin
        if (beat) begin
          if (idx_q == ptp_base + 11'(PTP_MSGTYPE_OFF)) begin
            msg_type_d = bus.s_axis_tdata[3:0];
            if (!is_event_msg(bus.s_axis_tdata[3:0])) state_d = StDrop;
          end else if (idx_q == ptp_base + 11'(PTP_SEQID_OFF)) begin
            seq_hi_d = bus.s_axis_tdata;
          end else if (idx_q == ptp_base + 11'(PTP_SEQID_OFF + 1)) begin
            seq_id_d = {seq_hi_q, bus.s_axis_tdata};
            state_d  = StTail;
          end
          // Runt: frame ended before the sequenceId was complete.
          if (last_beat) state_d = StIdle;
        end
      end
      StTail: begin
        if (last_beat) begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (last_beat) state_d = StIdle;
      end
      default: state_d = StResync;
    endcase
  end

  always_ff @(posedge rtc_clk) begin
    if (reset) begin
      state_q    <= StResync;
      idx_q      <= '0;
      vlan_q     <= 1'b0;
      etype_hi_q <= '0;
      seq_hi_q   <= '0;
      msg_type_q <= '0;
      seq_id_q   <= '0;
      ts_cap_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      vlan_q     <= vlan_d;
      etype_hi_q <= etype_hi_d;
      seq_hi_q   <= seq_hi_d;
      msg_type_q <= msg_type_d;
      seq_id_q   <= seq_id_d;
      ts_cap_q   <= ts_cap_d;
    end
  end

  tsu_ts_fifo #(
    .WIDTH   (REC_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk       (rtc_clk),
    .reset     (reset),
    .push      (push),
    .push_data (pack_rec(ts_cap_q, msg_type_q, seq_id_q)),
    .pop       (bus.ts_tready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Mirrors the FIFO acceptance rule: full and no effective pop loses the record.
  assign fifo_drop = push && fifo_full && !(bus.ts_tready && !fifo_empty);

  always_ff @(posedge rtc_clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (fifo_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.ts_tvalid   = !fifo_empty;
  assign bus.ts_tdata    = fifo_head;
  assign bus.ts_drop_cnt = drop_cnt_q;

endmodule
